// File: rtl/pipeline_hazard_pkg.sv
// Shared types for the hazard unit: forward-select encodings and the
// shadow-stage record that tracks an in-flight destination register.
package pipeline_hazard_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_BUS   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             reg_write;
    logic             mem_read;
  } shadow_t;

endpackage

// File: rtl/pipeline_fwd_match.sv
// Qualify a shadow-stage writer and compare its destination against one
// source index; also flags when that matching writer is a load.
module pipeline_fwd_match
  import pipeline_hazard_pkg::*;
(
  input  shadow_t          wr,
  input  logic [REG_W-1:0] src,
  output logic             hit,
  output logic             hit_load
);

  // $0 is hardwired, so a write to it is never a real producer
  assign hit      = wr.valid && wr.reg_write && (wr.dst != '0) && (wr.dst == src);
  assign hit_load = hit && wr.mem_read;

endmodule

// File: rtl/pipeline_hazard.sv
// ID-side hazard unit: shadow EX/MEM/WB destination tracking, registered
// EX forwarding selects, jr target forwarding, and stall/bubble generation.
module pipeline_hazard
  import pipeline_hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_valid,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             ID_ALUSrc1,
  input  logic             ID_ALUSrc2,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic [REG_W-1:0] ID_dst,
  input  logic             ID_jr,
  input  logic             EX_flush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [1:0]       ForwardJ,
  output logic             Stall,
  output logic             Bubble,
  output logic [CNT_W-1:0] StallCnt
);

  shadow_t ex_q, mem_q, wb_q;

  logic ex_rs_hit, ex_rs_load, ex_rt_hit, ex_rt_load;
  logic mem_rs_hit, mem_rs_load, mem_rt_hit, unused_mem_rt_load;
  logic wb_rs_hit, unused_wb_rs_load;

  pipeline_fwd_match u_ex_rs (.wr(ex_q), .src(ID_rs), .hit(ex_rs_hit), .hit_load(ex_rs_load));
  pipeline_fwd_match u_ex_rt (.wr(ex_q), .src(ID_rt), .hit(ex_rt_hit), .hit_load(ex_rt_load));
  pipeline_fwd_match u_mem_rs (.wr(mem_q), .src(ID_rs), .hit(mem_rs_hit), .hit_load(mem_rs_load));
  pipeline_fwd_match u_mem_rt (.wr(mem_q), .src(ID_rt), .hit(mem_rt_hit), .hit_load(unused_mem_rt_load));
  pipeline_fwd_match u_wb_rs (.wr(wb_q), .src(ID_rs), .hit(wb_rs_hit), .hit_load(unused_wb_rs_load));

  logic load_use, jr_hazard, hazard;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  always_comb begin
    load_use  = (ID_use_rs && ex_rs_load) || (ID_use_rt && ex_rt_load);
    jr_hazard = ID_jr && (ex_rs_hit || mem_rs_load);
    hazard    = ID_valid && (load_use || jr_hazard);

    // gated by reset so the controls drop the instant reset asserts
    Stall  = reset && hazard && !EX_flush;
    Bubble = reset && (hazard || EX_flush);

    ForwardJ = FWD_BUS;
    if (reset && ID_jr && !jr_hazard) begin
      if (mem_rs_hit && !mem_q.mem_read) ForwardJ = FWD_EXMEM;
      else if (wb_rs_hit)                ForwardJ = FWD_MEMWB;
    end

    fwd_a_nxt = FWD_BUS;
    if (ID_use_rs && !ID_ALUSrc1 && !Bubble) begin
      if (ex_rs_hit)       fwd_a_nxt = FWD_EXMEM;
      else if (mem_rs_hit) fwd_a_nxt = FWD_MEMWB;
    end

    fwd_b_nxt = FWD_BUS;
    if (ID_use_rt && !ID_ALUSrc2 && !Bubble) begin
      if (ex_rt_hit)       fwd_b_nxt = FWD_EXMEM;
      else if (mem_rt_hit) fwd_b_nxt = FWD_MEMWB;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      ForwardA <= FWD_BUS;
      ForwardB <= FWD_BUS;
      StallCnt <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (Bubble || !ID_valid) ex_q <= '0;
      else                     ex_q <= '{valid: 1'b1, dst: ID_dst,
                                         reg_write: ID_RegWrite, mem_read: ID_MemRead};
      ForwardA <= fwd_a_nxt;
      ForwardB <= fwd_b_nxt;
      if (Stall && (StallCnt != {CNT_W{1'b1}})) StallCnt <= StallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard.sv
// Table-driven bench for pipeline_hazard: each row is one ID cycle with its
// expected combinational controls and the forwarding selects it should latch.
module tb_pipeline_hazard;
  import pipeline_hazard_pkg::*;

  localparam int CNT_W = 16;

  logic             clk, reset;
  logic             ID_valid, ID_use_rs, ID_use_rt, ID_ALUSrc1, ID_ALUSrc2;
  logic             ID_RegWrite, ID_MemRead, ID_jr, EX_flush;
  logic [REG_W-1:0] ID_rs, ID_rt, ID_dst;
  logic [1:0]       ForwardA, ForwardB, ForwardJ;
  logic             Stall, Bubble;
  logic [CNT_W-1:0] StallCnt;

  pipeline_hazard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_ALUSrc1(ID_ALUSrc1),
    .ID_ALUSrc2(ID_ALUSrc2), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_dst(ID_dst), .ID_jr(ID_jr), .EX_flush(EX_flush), .ForwardA(ForwardA),
    .ForwardB(ForwardB), .ForwardJ(ForwardJ), .Stall(Stall), .Bubble(Bubble),
    .StallCnt(StallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v; int rs; int rt; bit urs; bit urt; bit a1; bit a2; bit rw; bit mr;
    int dst; bit jr; bit fl;
    bit st; bit bu; logic [1:0] fj; logic [1:0] fa; logic [1:0] fb;
  } vec_t;

  typedef struct {
    int idx; logic [1:0] fa; logic [1:0] fb; logic [CNT_W-1:0] cnt;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   total = 0;
  int   bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  function automatic vec_t op(input bit v, input int rs, input int rt, input bit urs,
                              input bit urt, input bit a1, input bit a2, input bit rw,
                              input bit mr, input int dst, input bit jr, input bit fl,
                              input bit st, input bit bu, input logic [1:0] fj,
                              input logic [1:0] fa, input logic [1:0] fb);
    vec_t r;
    r = '{v, rs, rt, urs, urt, a1, a2, rw, mr, dst, jr, fl, st, bu, fj, fa, fb};
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) tbl.push_back(op(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
  endtask

  task automatic drive(input vec_t r);
    ID_valid = r.v; ID_rs = REG_W'(r.rs); ID_rt = REG_W'(r.rt);
    ID_use_rs = r.urs; ID_use_rt = r.urt; ID_ALUSrc1 = r.a1; ID_ALUSrc2 = r.a2;
    ID_RegWrite = r.rw; ID_MemRead = r.mr; ID_dst = REG_W'(r.dst);
    ID_jr = r.jr; EX_flush = r.fl;
  endtask

  initial begin
    sb_t e;
    vec_t lw2, use2;
    // v rs rt urs urt a1 a2 rw mr dst jr fl | st bu fj fa fb
    // add $3 ; add $4,$3,$5 -> EX/MEM forward on A
    tbl.push_back(op(1, 1, 2,1,1,0,0,1,0, 3,0,0, 0,0,0,0,0));
    tbl.push_back(op(1, 3, 5,1,1,0,0,1,0, 4,0,0, 0,0,0,2,0));
    nops(3);
    // add $3 ; bubble ; sub $6,$5,$3 -> MEM/WB forward on B
    tbl.push_back(op(1, 1, 2,1,1,0,0,1,0, 3,0,0, 0,0,0,0,0));
    tbl.push_back(op(0, 0, 0,0,0,0,0,0,0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(op(1, 5, 3,1,1,0,0,1,0, 6,0,0, 0,0,0,0,1));
    nops(3);
    // two writers of $3: EX/MEM wins
    tbl.push_back(op(1, 1, 2,1,1,0,0,1,0, 3,0,0, 0,0,0,0,0));
    tbl.push_back(op(1, 1, 2,1,1,0,0,1,0, 3,0,0, 0,0,0,0,0));
    tbl.push_back(op(1, 3, 6,1,1,0,0,1,0, 9,0,0, 0,0,0,2,0));
    nops(3);
    // lw $2 ; add $7,$2,$2 -> one stall, then MEM/WB on both
    tbl.push_back(op(1, 1, 0,1,0,0,1,1,1, 2,0,0, 0,0,0,0,0));
    tbl.push_back(op(1, 2, 2,1,1,0,0,1,0, 7,0,0, 1,1,0,0,0));
    tbl.push_back(op(1, 2, 2,1,1,0,0,1,0, 7,0,0, 0,0,0,1,1));
    nops(3);
    // immediate and shamt operands never forwarded over
    tbl.push_back(op(1, 1, 2,1,1,0,0,1,0, 8,0,0, 0,0,0,0,0));
    tbl.push_back(op(1, 1, 8,1,1,0,1,1,0, 8,0,0, 0,0,0,0,0));
    tbl.push_back(op(1, 8, 8,1,1,1,0,1,0,10,0,0, 0,0,0,0,2));
    nops(3);
    // writes to $0 neither forward nor stall
    tbl.push_back(op(1, 1, 2,1,1,0,0,1,0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(op(1, 1, 0,1,0,0,1,1,1, 0,0,0, 0,0,0,0,0));
    tbl.push_back(op(1, 0, 0,1,1,0,0,1,0, 5,0,0, 0,0,0,0,0));
    nops(3);
    // load-use coinciding with a flush: bubble only
    tbl.push_back(op(1, 1, 0,1,0,0,1,1,1, 2,0,0, 0,0,0,0,0));
    tbl.push_back(op(1, 2, 2,1,1,0,0,1,0, 7,0,1, 0,1,0,0,0));
    nops(3);
    // lw $31 ; jr $31 -> two stalls then ForwardJ from MEM/WB
    tbl.push_back(op(1,29, 0,1,0,0,1,1,1,31,0,0, 0,0,0,0,0));
    tbl.push_back(op(1,31, 0,1,0,0,0,0,0, 0,1,0, 1,1,0,0,0));
    tbl.push_back(op(1,31, 0,1,0,0,0,0,0, 0,1,0, 1,1,0,0,0));
    tbl.push_back(op(1,31, 0,1,0,0,0,0,0, 0,1,0, 0,0,1,0,0));
    nops(3);
    // add $5 ; jr $5 -> one stall then ForwardJ from EX/MEM
    tbl.push_back(op(1, 1, 2,1,1,0,0,1,0, 5,0,0, 0,0,0,0,0));
    tbl.push_back(op(1, 5, 0,1,0,0,0,0,0, 0,1,0, 1,1,0,0,0));
    tbl.push_back(op(1, 5, 0,1,0,0,0,0,0, 0,1,0, 0,0,2,1,0));
    nops(3);

    // reset state, with a flush pending that must not raise Bubble
    reset = 1'b0;
    drive(op(0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0));
    #2;
    chk("rst_fa", -1, 32'(ForwardA), 0);
    chk("rst_fb", -1, 32'(ForwardB), 0);
    chk("rst_fj", -1, 32'(ForwardJ), 0);
    chk("rst_stall", -1, 32'(Stall), 0);
    chk("rst_bubble", -1, 32'(Bubble), 0);
    chk("rst_cnt", -1, 32'(StallCnt), 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk("stall", i, 32'(Stall), 32'(tbl[i].st));
      chk("bubble", i, 32'(Bubble), 32'(tbl[i].bu));
      chk("fwd_j", i, 32'(ForwardJ), 32'(tbl[i].fj));
      if (tbl[i].st) exp_cnt = exp_cnt + 1'b1;
      sb.push_back('{i, tbl[i].fa, tbl[i].fb, exp_cnt});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", i, 1, 0);
      end else begin
        e = sb.pop_front();
        chk("fwd_a", e.idx, 32'(ForwardA), 32'(e.fa));
        chk("fwd_b", e.idx, 32'(ForwardB), 32'(e.fb));
        chk("stall_cnt", e.idx, 32'(StallCnt), 32'(e.cnt));
      end
    end
    chk("cnt_total", -2, 32'(StallCnt), 4);

    // reset asserted in the middle of a load-use stall
    lw2  = op(1, 1, 0,1,0,0,1,1,1, 2,0,0, 0,0,0,0,0);
    use2 = op(1, 2, 2,1,1,0,0,1,0, 7,0,0, 0,0,0,0,0);
    @(negedge clk);
    drive(lw2);
    @(negedge clk);
    drive(use2);
    #1;
    chk("mid_stall", -3, 32'(Stall), 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_stall", -3, 32'(Stall), 0);
    chk("rst_mid_bubble", -3, 32'(Bubble), 0);
    chk("rst_mid_cnt", -3, 32'(StallCnt), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    // shadow stages were cleared, so the same consumer no longer stalls
    chk("post_rst_stall", -4, 32'(Stall), 0);
    @(posedge clk);
    #1;
    chk("post_rst_fa", -4, 32'(ForwardA), 0);
    chk("post_rst_cnt", -4, 32'(StallCnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
